// File: rtl/info_log_pkg.sv
// rtl/info_log_pkg.sv - shared types for the info log writer
package info_log_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef logic [15:0] drop_cnt_t;

  localparam drop_cnt_t DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/info_log_fifo.sv
// rtl/info_log_fifo.sv - synchronous FIFO, storage-register read port, async reset
module info_log_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push, do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/info_log_writer.sv
// rtl/info_log_writer.sv - FIFO-buffered info word logger onto a COLS x ROWS text RAM
// Define INFO_LOG_CLEAR_EN to blank each row before its column-0 write.
module info_log_writer
  import info_log_pkg::*;
#(
  parameter int            DW    = 16,
  parameter int            COLS  = 40,
  parameter int            ROWS  = 30,
  parameter int            DEPTH = 16,
  parameter logic [DW-1:0] BLANK = '0,
  localparam int           NCELL = COLS * ROWS,
  localparam int           CW    = $clog2(NCELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          home,
  output logic          wr_en,
  output logic [CW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [CW-1:0] cursor,
  output logic          full,
  output logic [15:0]   drops
);

  state_t        state, state_nxt;
  logic          fifo_full, fifo_empty, pop;
  logic [DW-1:0] fifo_data;
  logic          home_pend, home_eff, blank_wr;
  logic [CW-1:0] tgt, tgt_next, blank_addr;
  drop_cnt_t     drop_cnt;

  info_log_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data(in_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A home pulse in the same cycle as a pop already retargets that pop.
  assign home_eff = home || home_pend;
  assign tgt      = home_eff ? '0 : cursor;
  assign tgt_next = (tgt == CW'(NCELL - 1)) ? '0 : tgt + CW'(1);
  assign full     = fifo_full;
  assign drops    = drop_cnt;

`ifdef INFO_LOG_CLEAR_EN
  localparam int COLW = $clog2(COLS);

  logic [COLW-1:0] col, clr_col, tcol;
  logic [CW-1:0]   clr_addr;
  logic            cleared, start_clr;

  // A column-0 target starts the row blanking; its first blank write issues right away.
  assign tcol       = home_eff ? '0 : col;
  assign start_clr  = (state != CLEAR) && !fifo_empty && (tcol == '0) && (!cleared || home);
  assign blank_wr   = start_clr || (state == CLEAR);
  assign blank_addr = (state == CLEAR) ? clr_addr : tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      clr_col  <= '0;
      clr_addr <= '0;
      cleared  <= 1'b0;
    end else begin
      if (pop) col <= (tcol == COLW'(COLS - 1)) ? '0 : tcol + COLW'(1);
      if (start_clr) begin
        clr_col  <= COLW'(1);
        clr_addr <= tgt + CW'(1);
      end else if (state == CLEAR) begin
        clr_col  <= clr_col + COLW'(1);
        clr_addr <= clr_addr + CW'(1);
      end
      if (home || pop)
        cleared <= 1'b0;
      else if (state == CLEAR && clr_col == COLW'(COLS - 1))
        cleared <= 1'b1;
    end
  end
`else
  assign blank_wr   = 1'b0;
  assign blank_addr = '0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE, WRITE: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
`ifdef INFO_LOG_CLEAR_EN
        end else if (start_clr) begin
          state_nxt = CLEAR;
`endif
        end else begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end
      end
`ifdef INFO_LOG_CLEAR_EN
      CLEAR: if (clr_col == COLW'(COLS - 1)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cursor    <= '0;
      home_pend <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wr_en <= pop || blank_wr;
      if (pop || blank_wr) begin
        wr_addr <= blank_wr ? blank_addr : tgt;
        wr_data <= blank_wr ? BLANK : fifo_data;
      end
      if (pop) cursor <= tgt_next;
      home_pend <= pop ? 1'b0 : (home_pend || home);
      if (in_valid && fifo_full && !pop && drop_cnt != DROP_MAX)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_info_log_writer.sv
// tb/tb_info_log_writer.sv - table plus scoreboard bench for info_log_writer
`timescale 1ns/1ps
module tb_info_log_writer;

  localparam int COLS  = 40;
  localparam int NCELL = 1200;
`ifdef INFO_LOG_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        testclk = 1'b0;
  logic        rst, in_valid, home;
  logic [15:0] in_data;
  logic        wr_en, full;
  logic [10:0] wr_addr, cursor;
  logic [15:0] wr_data, drops;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          mode;
    logic [15:0] data;
    int          exp_addr;
    int          exp_cursor;
  } vec_t;

  wr_t         exp_q[$];
  int          checks = 0, failures = 0, wr_count = 0;
  bit          full_seen = 1'b0;
  int          m_cursor = 0;
  bit          m_home_pend = 1'b0;
  logic [10:0] last_addr = '0;
  logic [15:0] last_data = '0;

  always #5 testclk = ~testclk;

  info_log_writer dut (
    .clk     (testclk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .home    (home),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cursor  (cursor),
    .full    (full),
    .drops   (drops)
  );

  task automatic check(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge testclk) begin
    wr_t e;
    if (!rst) begin
      if (full) full_seen = 1'b1;
      if (wr_en) begin
        wr_count++;
        last_addr = wr_addr;
        last_data = wr_data;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", wr_addr, e.addr);
          check("sb_data", wr_data, e.data);
        end
      end
    end
  end

  // Reference model of where each accepted word lands, including row blanking.
  function automatic void model_write(logic [15:0] d, bit home_now);
    int t;
    t = (home_now || m_home_pend) ? 0 : m_cursor;
    m_home_pend = 1'b0;
    if (CLR_EN && (t % COLS == 0))
      for (int c = 0; c < COLS; c++) exp_q.push_back('{addr: 11'(t + c), data: 16'h0000});
    exp_q.push_back('{addr: 11'(t), data: d});
    m_cursor = (t == NCELL - 1) ? 0 : t + 1;
  endfunction

  task automatic drive(logic [15:0] d, bit h, bit v, bit dropped);
    @(posedge testclk); #1;
    in_valid = v;
    in_data  = d;
    home     = h;
    if (v && !dropped) model_write(d, h);
    else if (h)        m_home_pend = 1'b1;
  endtask

  task automatic idle();
    @(posedge testclk); #1;
    in_valid = 1'b0;
    home     = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge testclk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge testclk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    home     = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge testclk);
    #1;
    exp_q.delete();
    m_cursor    = 0;
    m_home_pend = 1'b0;
    full_seen   = 1'b0;
    rst         = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   wc0;
    vecs[0] = '{0, 16'h0001, 1, 2};
    vecs[1] = '{0, 16'h0002, 2, 3};
    vecs[2] = '{0, 16'h0003, 3, 4};
    vecs[3] = '{0, 16'h0004, 4, 5};
    vecs[4] = '{1, 16'hAAAA, 0, 1};
    vecs[5] = '{0, 16'hBBBB, 1, 2};
    vecs[6] = '{2, 16'hCCCC, 0, 1};
    vecs[7] = '{3, 16'hDDDD, 0, 1};
    vecs[8] = '{0, 16'hEEEE, 1, 2};

    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cursor", cursor, 0);
    check("rst_full", full, 0);
    check("rst_drops", drops, 0);

    // One word: sampled at edge N, written after edge N+1.
    drive(16'h1234, 1'b0, 1'b1, 1'b0);
    idle();
    check("lat_n_wr_en", wr_en, 0);
    @(posedge testclk); #1;
    check("lat_n1_wr_en", wr_en, 1);
    check("lat_n1_addr", wr_addr, 0);
    check("lat_n1_data", wr_data, CLR_EN ? 16'h0000 : 16'h1234);
    wait_drain("lat_drain", 200);
    check("lat_cursor", cursor, 1);

    // Table of words with home pulses: 1 before, 2 coincident, 3 doubled before.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].mode == 1 || vecs[i].mode == 3) begin
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        idle();
      end
      if (vecs[i].mode == 3) begin
        drive(16'h0000, 1'b1, 1'b0, 1'b0);
        idle();
      end
      drive(vecs[i].data, vecs[i].mode == 2, 1'b1, 1'b0);
      idle();
      wait_drain("vec_drain", 200);
      check("vec_addr", last_addr, vecs[i].exp_addr);
      check("vec_data", last_data, vecs[i].data);
      check("vec_cursor", cursor, vecs[i].exp_cursor);
    end

`ifndef INFO_LOG_CLEAR_EN
    // Full screen plus one word at 1/cycle wraps back to cell 0.
    do_reset();
    for (int i = 0; i < NCELL + 1; i++) drive(16'(i + 16'h0100), 1'b0, 1'b1, 1'b0);
    idle();
    wait_drain("wrap_drain", 100);
    check("wrap_last_addr", last_addr, 0);
    check("wrap_last_data", last_data, 16'(NCELL + 16'h0100));
    check("wrap_cursor", cursor, 1);
    check("wrap_drops", drops, 0);
    check("wrap_full_seen", full_seen, 0);

    wc0 = wr_count;
    for (int i = 0; i < 20; i++) drive(16'(16'h5000 + i), 1'b0, 1'b1, 1'b0);
    idle();
    wait_drain("burst_drain", 100);
    check("burst_writes", wr_count - wc0, 20);
    check("burst_drops", drops, 0);
    check("burst_full_seen", full_seen, 0);
`else
    // Trigger word starts a 40-cycle clear; 16 words fit, 4 are lost.
    do_reset();
    for (int i = 0; i < 20; i++) drive(16'(16'h7000 + i), 1'b0, 1'b1, i >= 16);
    idle();
    check("ovf_drops_early", drops, 4);
    wait_drain("ovf_drain", 300);
    check("ovf_drops", drops, 4);
    check("ovf_full_seen", full_seen, 1);
    check("ovf_cursor", cursor, 16);

    // Row 0 is blanked before the first word; word 41 blanks row 1 first.
    do_reset();
    drive(16'h5555, 1'b0, 1'b1, 1'b0);
    idle();
    wait_drain("clr_first_drain", 200);
    check("clr_first_addr", last_addr, 0);
    check("clr_first_data", last_data, 16'h5555);
    for (int i = 1; i < 41; i++) drive(16'(16'h6000 + i), 1'b0, 1'b1, 1'b0);
    idle();
    wait_drain("clr_row1_drain", 300);
    check("clr_row1_addr", last_addr, 40);
    check("clr_row1_cursor", cursor, 41);
`endif

    // Reset mid-burst: write strobe falls at once and nothing stale follows.
    do_reset();
    for (int i = 0; i < 8; i++) drive(16'(16'h9000 + i), 1'b0, 1'b1, 1'b0);
    idle();
    check("mid_wr_en_busy", wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    exp_q.delete();
    m_cursor    = 0;
    m_home_pend = 1'b0;
    repeat (2) @(posedge testclk);
    #1;
    rst = 1'b0;
    check("mid_cursor", cursor, 0);
    check("mid_drops", drops, 0);
    check("mid_full", full, 0);
    wc0 = wr_count;
    repeat (60) @(posedge testclk);
    #1;
    check("mid_no_stale", wr_count - wc0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
